// File: rtl/ropuf_pair_reader.sv
// rtl/ropuf_pair_reader.sv - RO-PUF pair measurement: count two RO edge streams over a window, compare
//
// Enables two challenge-selected ring oscillators, synchronises each selected RO
// output into the clk domain, counts its rising edges during a fixed window and
// reports which oscillator was faster as a single response bit.
//
// Optional feature macro: ROPUF_TIE_FLAG_EN (adds the `tie` output).
//
// Ports:
//   clk     in   1       system clock
//   rst     in   1       synchronous active-high reset
//   start   in   1       measurement request, honoured only when idle
//   sel_a   in   SEL_W   challenge index of RO A
//   sel_b   in   SEL_W   challenge index of RO B
//   ro_out  in   NUM_RO  RO outputs (asynchronous to clk)
//   ro_en   out  NUM_RO  RO enables, only the two latched challenge bits
//   busy    out  1       measurement in progress
//   done    out  1       one-cycle pulse, results valid
//   resp    out  1       1 when cnt_a > cnt_b
//   cnt_a   out  CNT_W   edge count of RO A, last measurement
//   cnt_b   out  CNT_W   edge count of RO B, last measurement
//   tie     out  1       (ROPUF_TIE_FLAG_EN only) cnt_a == cnt_b, last measurement

module ropuf_pair_reader #(
   parameter int NUM_RO     = 4,
   parameter int SEL_W      = 2,
   parameter int CNT_W      = 16,
   parameter int WIN_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [SEL_W-1:0]  sel_a,
   input  logic [SEL_W-1:0]  sel_b,
   input  logic [NUM_RO-1:0] ro_out,
   output logic [NUM_RO-1:0] ro_en,
   output logic              busy,
   output logic              done,
   output logic              resp,
   output logic [CNT_W-1:0]  cnt_a,
`ifdef ROPUF_TIE_FLAG_EN
   output logic [CNT_W-1:0]  cnt_b,
   output logic              tie
`else
   output logic [CNT_W-1:0]  cnt_b
`endif
);

   // Timer must hold WIN_CYCLES-1 and the settle length of 4 cycles.
   localparam int TMR_W = $clog2(WIN_CYCLES + 4) + 1;
   localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(3);
   localparam logic [TMR_W-1:0] COUNT_LAST  = TMR_W'(WIN_CYCLES - 1);
   localparam logic [TMR_W-1:0] DRAIN_LAST  = TMR_W'(1);
   localparam logic [SEL_W:0]   NUM_RO_W    = (SEL_W + 1)'(NUM_RO);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_COUNT,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [TMR_W-1:0]  tmr;
   logic              tmr_clr;
   logic              accept;
   logic              counting;
   logic              clear_cnt;
   logic              load;
   logic              sel_ok;

   logic [SEL_W-1:0]  sel_a_q;
   logic [SEL_W-1:0]  sel_b_q;
   logic [1:0]        sync_a;
   logic [1:0]        sync_b;
   logic              prev_a;
   logic              prev_b;
   logic              rise_a;
   logic              rise_b;
   logic [CNT_W-1:0]  acc_a;
   logic [CNT_W-1:0]  acc_b;

   assign sel_ok = (sel_a != sel_b) && ({1'b0, sel_a} < NUM_RO_W) && ({1'b0, sel_b} < NUM_RO_W);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         tmr   <= '0;
      end else begin
         state <= state_nxt;
         if (tmr_clr) tmr <= '0;
         else         tmr <= tmr + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      tmr_clr   = 1'b0;
      accept    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      counting  = 1'b0;
      clear_cnt = 1'b0;
      load      = 1'b0;
      case (state)
         S_IDLE: begin
            tmr_clr = 1'b1;
            if (start && sel_ok) begin
               accept    = 1'b1;
               state_nxt = S_SETTLE;
            end
         end
         S_SETTLE: begin
            busy      = 1'b1;
            clear_cnt = 1'b1;
            if (tmr == SETTLE_LAST) begin
               state_nxt = S_COUNT;
               tmr_clr   = 1'b1;
            end
         end
         S_COUNT: begin
            busy     = 1'b1;
            counting = 1'b1;
            if (tmr == COUNT_LAST) begin
               state_nxt = S_DRAIN;
               tmr_clr   = 1'b1;
            end
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (tmr == DRAIN_LAST) begin
               state_nxt = S_DONE;
               tmr_clr   = 1'b1;
               load      = 1'b1;   // results become visible in the DONE cycle
            end
         end
         S_DONE: begin
            done      = 1'b1;
            tmr_clr   = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
            tmr_clr   = 1'b1;
         end
      endcase
   end

   always_comb begin
      ro_en = '0;
      for (int i = 0; i < NUM_RO; i++) begin
         ro_en[i] = busy && ((sel_a_q == SEL_W'(i)) || (sel_b_q == SEL_W'(i)));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_a_q <= '0;
         sel_b_q <= '0;
      end else if (accept) begin
         sel_a_q <= sel_a;
         sel_b_q <= sel_b;
      end
   end

   // The mux only changes at accept; the SETTLE cycles flush the chain
   // before any edge is counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_a <= '0;
         sync_b <= '0;
         prev_a <= 1'b0;
         prev_b <= 1'b0;
      end else begin
         sync_a <= {sync_a[0], ro_out[sel_a_q]};
         sync_b <= {sync_b[0], ro_out[sel_b_q]};
         prev_a <= sync_a[1];
         prev_b <= sync_b[1];
      end
   end

   assign rise_a = sync_a[1] & ~prev_a;
   assign rise_b = sync_b[1] & ~prev_b;

   always_ff @(posedge clk) begin
      if (rst || clear_cnt) begin
         acc_a <= '0;
         acc_b <= '0;
      end else if (counting) begin
         if (rise_a && (acc_a != CNT_MAX)) acc_a <= acc_a + 1'b1;
         if (rise_b && (acc_b != CNT_MAX)) acc_b <= acc_b + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_a <= '0;
         cnt_b <= '0;
         resp  <= 1'b0;
      end else if (load) begin
         cnt_a <= acc_a;
         cnt_b <= acc_b;
         resp  <= (acc_a > acc_b);
      end
   end

`ifdef ROPUF_TIE_FLAG_EN
   always_ff @(posedge clk) begin
      if (rst)       tie <= 1'b0;
      else if (load) tie <= (acc_a == acc_b);
   end
`endif

endmodule

// File: tb/tb_ropuf_pair_reader.sv
// tb/tb_ropuf_pair_reader.sv - self-checking bench for ropuf_pair_reader (16-bit and 4-bit counter builds)

module tb_ropuf_pair_reader;

   localparam int WIN = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] sel_a;
   logic [1:0] sel_b;
   logic [3:0] ro_out = 4'b0;

   logic [3:0]  ro_en16, ro_en4;
   logic        busy16, busy4, done16, done4, resp16, resp4;
   logic [15:0] cnt_a16, cnt_b16;
   logic [3:0]  cnt_a4, cnt_b4;
`ifdef ROPUF_TIE_FLAG_EN
   logic        tie16, tie4;
`endif

   ropuf_pair_reader #(.NUM_RO(4), .SEL_W(2), .CNT_W(16), .WIN_CYCLES(WIN)) u16 (
      .clk(clk), .rst(rst), .start(start), .sel_a(sel_a), .sel_b(sel_b), .ro_out(ro_out),
      .ro_en(ro_en16), .busy(busy16), .done(done16), .resp(resp16), .cnt_a(cnt_a16),
`ifdef ROPUF_TIE_FLAG_EN
      .tie(tie16),
`endif
      .cnt_b(cnt_b16));

   ropuf_pair_reader #(.NUM_RO(4), .SEL_W(2), .CNT_W(4), .WIN_CYCLES(WIN)) u4 (
      .clk(clk), .rst(rst), .start(start), .sel_a(sel_a), .sel_b(sel_b), .ro_out(ro_out),
      .ro_en(ro_en4), .busy(busy4), .done(done4), .resp(resp4), .cnt_a(cnt_a4),
`ifdef ROPUF_TIE_FLAG_EN
      .tie(tie4),
`endif
      .cnt_b(cnt_b4));

   always #5 clk = ~clk;

   int ntests = 0;
   int nfail  = 0;

   task automatic chk(input string nm, input int act, input int lo, input int hi);
      ntests++;
      if (act < lo || act > hi) begin
         nfail++;
         if (lo == hi) $display("FAIL %s: got %0d, expected %0d", nm, act, lo);
         else          $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   // RO models: clk-synchronous square waves, period 0 = stuck low
   int per [4] = '{0, 0, 0, 0};
   int ph  [4] = '{0, 0, 0, 0};
   int cyc = 0;

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 4; i++)
         ro_out[i] = (per[i] == 0) ? 1'b0 : (((cyc + ph[i]) % per[i]) < (per[i] / 2));
   end

   // Model: measurement accepted at edge k -> busy k+1..k+70, done k+71.
   // Counts = rising edges of the chosen RO within the window, +-1 for sync latency.
   logic [3:0] samp [0:8191];
   bit   active = 0;
   int   k = 0;
   int   msel_a = 0, msel_b = 0;
   int   lo_a16 = 0, hi_a16 = 0, lo_b16 = 0, hi_b16 = 0;
   int   lo_a4 = 0, hi_a4 = 0, lo_b4 = 0, hi_b4 = 0;
   int   e_resp16 = 0, e_resp4 = 0, e_tie = 0;
   int   n_done16 = 0;

   function automatic int sat(input int v, input int mx);
      if (v < 0) return 0;
      return (v > mx) ? mx : v;
   endfunction

   function automatic int edges(input int s);
      int n = 0;
      for (int e = k + 5; e <= k + WIN + 4; e++)
         if (samp[e][s] && !samp[e-1][s]) n++;
      return n;
   endfunction

   always @(posedge clk) begin
      int ra, rb;
      samp[cyc % 8192] = ro_out;
      if (rst) begin
         active = 0;
         lo_a16 = 0; hi_a16 = 0; lo_b16 = 0; hi_b16 = 0;
         lo_a4  = 0; hi_a4  = 0; lo_b4  = 0; hi_b4  = 0;
         e_resp16 = 0; e_resp4 = 0; e_tie = 0;
      end else begin
         if (active && cyc == k + WIN + 6) begin
            ra = edges(msel_a);
            rb = edges(msel_b);
            lo_a16 = sat(ra - 1, 65535); hi_a16 = sat(ra + 1, 65535);
            lo_b16 = sat(rb - 1, 65535); hi_b16 = sat(rb + 1, 65535);
            lo_a4  = sat(ra - 1, 15);    hi_a4  = sat(ra + 1, 15);
            lo_b4  = sat(rb - 1, 15);    hi_b4  = sat(rb + 1, 15);
            e_resp16 = (sat(ra, 65535) > sat(rb, 65535)) ? 1 : 0;
            e_resp4  = (sat(ra, 15) > sat(rb, 15)) ? 1 : 0;
            e_tie    = (ra == rb) ? 1 : 0;
         end
         if (!(active && cyc >= k + 1 && cyc <= k + WIN + 7) &&
             start && sel_a != sel_b) begin
            active = 1;
            k      = cyc;
            msel_a = int'(sel_a);
            msel_b = int'(sel_b);
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      bit   b, d;
      logic [3:0] m;
      if (cyc >= 1) begin
         b = active && cyc >= k + 1 && cyc <= k + WIN + 6;
         d = active && cyc == k + WIN + 7;
         m = 4'b0;
         if (b) begin
            m[msel_a] = 1'b1;
            m[msel_b] = 1'b1;
         end
         if (done16) n_done16++;
         chk("busy16",  int'(busy16),  int'(b), int'(b));
         chk("done16",  int'(done16),  int'(d), int'(d));
         chk("ro_en16", int'(ro_en16), int'(m), int'(m));
         chk("busy4",   int'(busy4),   int'(b), int'(b));
         chk("done4",   int'(done4),   int'(d), int'(d));
         chk("ro_en4",  int'(ro_en4),  int'(m), int'(m));
         chk("cnt_a16", int'(cnt_a16), lo_a16, hi_a16);
         chk("cnt_b16", int'(cnt_b16), lo_b16, hi_b16);
         chk("cnt_a4",  int'(cnt_a4),  lo_a4,  hi_a4);
         chk("cnt_b4",  int'(cnt_b4),  lo_b4,  hi_b4);
         chk("resp16",  int'(resp16),  e_resp16, e_resp16);
         chk("resp4",   int'(resp4),   e_resp4,  e_resp4);
`ifdef ROPUF_TIE_FLAG_EN
         chk("tie16",   int'(tie16),   e_tie, e_tie);
         chk("tie4",    int'(tie4),    e_tie, e_tie);
`endif
      end
   end

   // start is sampled at the next edge (edge k); returns in cycle k+1 with sel scrambled
   task automatic kick(input int a, input int b);
      @(negedge clk);
      sel_a = 2'(a);
      sel_b = 2'(b);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      sel_a = 2'(b + 1);
      sel_b = 2'(a + 3);
   endtask

   task automatic meas(input int a, input int b);
      kick(a, b);
      repeat (WIN + 11) @(negedge clk);
   endtask

   int d0;

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      sel_a = 2'd0;
      sel_b = 2'd0;
      repeat (3) @(negedge clk);
      chk("reset_busy", int'(busy16), 0, 0);
      chk("reset_cnt_a", int'(cnt_a16), 0, 0);
      rst = 1'b0;

      // 1: RO0 period 8, RO1 period 16
      per[0] = 8; per[1] = 16;
      meas(0, 1);
      chk("t1_cnt_a", int'(cnt_a16), 7, 9);
      chk("t1_cnt_b", int'(cnt_b16), 3, 5);
      chk("t1_resp",  int'(resp16),  1, 1);

      // 2: swapped challenge
      meas(1, 0);
      chk("t2_cnt_a", int'(cnt_a16), 3, 5);
      chk("t2_cnt_b", int'(cnt_b16), 7, 9);
      chk("t2_resp",  int'(resp16),  0, 0);

      // 3: identical in-phase ROs -> tie, resp 0
      per[2] = 8; per[3] = 8;
      meas(2, 3);
      chk("t3_equal", int'(cnt_a16 == cnt_b16), 1, 1);
      chk("t3_resp",  int'(resp16), 0, 0);
`ifdef ROPUF_TIE_FLAG_EN
      chk("t3_tie",   int'(tie16), 1, 1);
`endif

      // 4: saturation in the 4-bit build
      per[0] = 4; per[1] = 32;
      meas(0, 1);
      chk("t4_cnt_a4", int'(cnt_a4), 15, 15);
      chk("t4_cnt_b4", int'(cnt_b4), 1, 3);
      chk("t4_resp4",  int'(resp4),  1, 1);
      chk("t4_cnt_a16", int'(cnt_a16), 15, 17);

      // 5: invalid challenge, then start during busy
      per[0] = 8; per[1] = 16;
      kick(1, 1);
      repeat (10) @(negedge clk);
      chk("t5_inv_busy", int'(busy16), 0, 0);
      chk("t5_inv_en",   int'(ro_en16), 0, 0);
      d0 = n_done16;
      kick(0, 1);
      repeat (8) @(negedge clk);
      sel_a = 2'd2; sel_b = 2'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (WIN + 10) @(negedge clk);
      chk("t5_one_done", n_done16 - d0, 1, 1);
      chk("t5_resp",     int'(resp16), 1, 1);

      // 6: reset during COUNT at edge k+30
      kick(0, 1);
      repeat (29) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_busy",  int'(busy16),  0, 0);
      chk("t6_en",    int'(ro_en16), 0, 0);
      chk("t6_cnt_a", int'(cnt_a16), 0, 0);
      chk("t6_resp",  int'(resp16),  0, 0);
      d0 = n_done16;
      repeat (WIN + 10) @(negedge clk);
      chk("t6_no_done", n_done16 - d0, 0, 0);
      meas(0, 1);
      chk("t6_cnt_a_after", int'(cnt_a16), 7, 9);
      chk("t6_resp_after",  int'(resp16),  1, 1);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
